// File: rtl/accelerator_activation_pkg.sv
// Shared constants for the SiLU activation stage: Q8.8 clamp window and the
// 16-segment piecewise-linear sigmoid table (intercepts and per-segment slopes).
package accelerator_activation_pkg;

    localparam int ACT_DATA_W = 16;

    localparam logic signed [15:0] ACT_CLAMP_LO = -16'sd2048;
    localparam logic signed [15:0] ACT_CLAMP_HI = 16'sd2047;

    // SIG_ICPT[k] = round(256*sigma(k-8)); SIG_SLOPE[k] = round(256*sigma(k-7)) - SIG_ICPT[k]
    localparam logic [8:0] SIG_ICPT [16] = '{
        9'd0,   9'd0,   9'd1,   9'd2,   9'd5,   9'd12,  9'd31,  9'd69,
        9'd128, 9'd187, 9'd225, 9'd244, 9'd251, 9'd254, 9'd255, 9'd256
    };
    localparam logic [8:0] SIG_SLOPE [16] = '{
        9'd0,  9'd1,  9'd1,  9'd3,  9'd7,  9'd19, 9'd38, 9'd59,
        9'd59, 9'd38, 9'd19, 9'd7,  9'd3,  9'd1,  9'd1,  9'd0
    };

    typedef struct packed {
        logic last;
        logic bypass;
    } beat_ctrl_t;

endpackage

// File: rtl/silu_lane.sv
// One lane of the SiLU datapath: S1 range split, S2 sigmoid lookup/interpolation,
// S3 rounded x*s product (or raw x for bypass beats).
module silu_lane
    import accelerator_activation_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         stage_en,
    input  logic               bypass,
    input  logic signed [15:0] x,
    output logic signed [15:0] y
);

    logic               lo, hi;
    logic        [11:0] xc, u;
    logic signed [15:0] x1, x2;
    logic        [3:0]  seg1;
    logic        [7:0]  frac1;
    logic               lo1, hi1;
    logic        [8:0]  s_next, s2;
    logic signed [15:0] y_next;

    // Clamped value lies in -2048..2047, so adding 2048 modulo 4096 is the offset index.
    always_comb begin
        lo = (x < ACT_CLAMP_LO);
        hi = (x > ACT_CLAMP_HI);
        if (lo)      xc = 12'h800;
        else if (hi) xc = 12'h7FF;
        else         xc = x[11:0];
        u = xc + 12'h800;
    end

    always_comb begin
        if (lo1)      s_next = 9'd0;
        else if (hi1) s_next = 9'd256;
        else          s_next = SIG_ICPT[seg1] + 9'((17'(SIG_SLOPE[seg1]) * 17'(frac1)) >> 8);
    end

    // s <= 256 keeps |y| <= |x|, so the truncation to 16 bits never overflows.
    always_comb begin
        if (bypass) y_next = x2;
        else        y_next = 16'((26'(x2) * 26'(signed'({1'b0, s2})) + 26'sd128) >>> 8);
    end

    // NOTE: internal datapath registers carry no reset; the stage valids in the top
    // level qualify them. Only y is reset because it is visible on out_data.
    always_ff @(posedge clk) begin
        if (stage_en[0]) begin
            x1    <= x;
            seg1  <= u[11:8];
            frac1 <= u[7:0];
            lo1   <= lo;
            hi1   <= hi;
        end
        if (stage_en[1]) begin
            x2 <= x1;
            s2 <= s_next;
        end
        if (rst)              y <= '0;
        else if (stage_en[2]) y <= y_next;
    end

endmodule

// File: rtl/silu_activation_unit.sv
// Streaming SiLU stage: LANES parallel silu_lane datapaths behind a three-stage
// valid/ready pipeline with collapsing bubbles and an output beat counter.
module silu_activation_unit
    import accelerator_activation_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int DATA_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic                    in_last,
    input  logic                    in_bypass,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    out_last,
    output logic [31:0]             beat_cnt
);

    if (DATA_W != ACT_DATA_W) begin : g_width_check
        $error("silu_activation_unit: DATA_W must be 16 (signed Q8.8)");
    end

    logic       v1, v2;
    logic       ld1, ld2, ld3, fire;
    logic [2:0] stage_en;
    beat_ctrl_t ctrl1, ctrl2;

    // Each stage loads when empty or when the stage after it loads.
    always_comb begin
        ld3      = out_ready | ~out_valid;
        ld2      = ~v2 | ld3;
        ld1      = ~v1 | ld2;
        in_ready = ld1;
        stage_en = {ld3 & v2, ld2 & v1, ld1 & in_valid};
        fire     = out_valid & out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            if (ld1) v1        <= in_valid;
            if (ld2) v2        <= v1;
            if (ld3) out_valid <= v2;
            if (stage_en[2]) out_last <= ctrl2.last;
            beat_cnt <= beat_cnt + 32'(fire);
        end
        if (stage_en[0]) ctrl1 <= '{last: in_last, bypass: in_bypass};
        if (stage_en[1]) ctrl2 <= ctrl1;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        silu_lane u_lane (
            .clk      (clk),
            .rst      (rst),
            .stage_en (stage_en),
            .bypass   (ctrl2.bypass),
            .x        (in_data[i*DATA_W +: DATA_W]),
            .y        (out_data[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_silu_activation_unit.sv
// Self-checking bench for silu_activation_unit: directed vectors plus randomized
// traffic scored against a sigmoid-table model built from real-valued sigma().
module tb_silu_activation_unit;

    localparam int LANES  = 8;
    localparam int DATA_W = 16;
    localparam int DW     = LANES * DATA_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_bypass = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [31:0]   beat_cnt;

    int checks = 0;
    int errors = 0;
    int icpt [16];
    int slope[16];

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];

    silu_activation_unit #(.LANES(LANES), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic init_tables();
        for (int k = 0; k < 16; k++) begin
            icpt[k]  = $rtoi(256.0 / (1.0 + $exp(real'(8 - k))) + 0.5);
            slope[k] = $rtoi(256.0 / (1.0 + $exp(real'(7 - k))) + 0.5) - icpt[k];
        end
    endtask

    function automatic logic [15:0] silu_ref(input logic [15:0] xb);
        int x, u, s;
        x = int'($signed(xb));
        if (x < -2048)     s = 0;
        else if (x >= 2048) s = 256;
        else begin
            u = x + 2048;
            s = icpt[u / 256] + (slope[u / 256] * (u % 256)) / 256;
        end
        return 16'((x * s + 128) >>> 8);
    endfunction

    function automatic logic [DW-1:0] model_beat(input logic [DW-1:0] d, input logic byp);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++)
            r[i*DATA_W +: DATA_W] = byp ? d[i*DATA_W +: DATA_W] : silu_ref(d[i*DATA_W +: DATA_W]);
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] d;
        for (int i = 0; i < LANES; i++) begin
            if ($urandom_range(1, 0) == 1)
                d[i*DATA_W +: DATA_W] = 16'(int'($urandom_range(4400, 0)) - 2200);
            else
                d[i*DATA_W +: DATA_W] = 16'($urandom);
        end
        return d;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Drive inputs at the falling edge, then report which handshakes the next rising edge completes.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic b,
                        input logic r, output logic acc_in, output logic acc_out);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        in_bypass = b;
        out_ready = r;
        #1;
        acc_in  = in_valid & in_ready;
        acc_out = out_valid & out_ready;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (beat_cnt !== 32'd0) begin errors++; $display("FAIL reset_beat_cnt got %0d want 0", beat_cnt); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_vectors();
        logic [15:0]   vin [LANES] = '{16'd0, 16'd256, -16'sd256, -16'sd4096, 16'd4096, 16'd32767, 16'h8000, 16'd2047};
        int            want[LANES] = '{0, 187, -69, 0, 4096, 32767, 0, 2047};
        logic [DW-1:0] d;
        logic          ai, ao;
        int            k;
        logic signed [15:0] got;
        apply_reset();
        for (int i = 0; i < LANES; i++) d[i*DATA_W +: DATA_W] = vin[i];
        step(1'b1, d, 1'b1, 1'b0, 1'b1, ai, ao);
        checks++; if (ai !== 1'b1) begin errors++; $display("FAIL vec_accept got %b want 1", ai); end
        k = 0;
        do begin
            k++;
            step(1'b0, '0, 1'b0, 1'b0, 1'b1, ai, ao);
        end while (out_valid !== 1'b1 && k < 10);
        checks++; if (k !== 3) begin errors++; $display("FAIL vec_latency got %0d want 3", k); end
        for (int i = 0; i < LANES; i++) begin
            got = out_data[i*DATA_W +: DATA_W];
            checks++;
            if (i == 7) begin
                if (int'(got) - int'($signed(silu_ref(vin[i]))) > 1 || int'($signed(silu_ref(vin[i]))) - int'(got) > 1) begin
                    errors++; $display("FAIL vec_lane%0d got %0d want %0d+-1", i, got, $signed(silu_ref(vin[i])));
                end
            end else if (int'(got) !== want[i]) begin
                errors++; $display("FAIL vec_lane%0d got %0d want %0d", i, got, want[i]);
            end
        end
        checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL vec_last got %b want 1", out_last); end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] d;
        logic          l, ai, ao;
        int            k;
        apply_reset();
        for (int t = 0; t < 2; t++) begin
            d = (t == 0) ? {LANES{16'h8000}} : rand_beat();
            l = (t == 0);
            step(1'b1, d, l, 1'b1, 1'b1, ai, ao);
            k = 0;
            do begin
                k++;
                step(1'b0, '0, 1'b0, 1'b0, 1'b1, ai, ao);
            end while (out_valid !== 1'b1 && k < 10);
            checks++; if (out_data !== d) begin errors++; $display("FAIL bypass_data%0d got %h want %h", t, out_data, d); end
            checks++; if (out_last !== l) begin errors++; $display("FAIL bypass_last%0d got %b want %b", t, out_last, l); end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        logic          ai, ao, l, want_v;
        int            sent = 0;
        beat_t         e;
        apply_reset();
        for (int j = 0; j < 106; j++) begin
            d = rand_beat();
            l = (sent == 99);
            step(sent < 100, d, l, 1'b0, 1'b1, ai, ao);
            want_v = (j >= 3 && j <= 102);
            checks++; if (out_valid !== want_v) begin errors++; $display("FAIL b2b_out_valid step %0d got %b want %b", j, out_valid, want_v); end
            if (sent < 100) begin
                checks++; if (ai !== 1'b1) begin errors++; $display("FAIL b2b_in_ready step %0d got %b want 1", j, in_ready); end
            end
            if (ai) begin
                exp_q.push_back('{data: model_beat(d, 1'b0), last: l});
                sent++;
            end
            if (ao) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_beat step %0d got %h want none", j, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_last !== e.last) begin
                        errors++; $display("FAIL b2b_data step %0d got %h/%b want %h/%b", j, out_data, out_last, e.data, e.last);
                    end
                end
            end
        end
        checks++; if (beat_cnt !== 32'd100) begin errors++; $display("FAIL b2b_beat_cnt got %0d want 100", beat_cnt); end
    endtask

    task automatic test_random_stall();
        logic [DW-1:0] d, hold_data;
        logic          v, l, b, r, ai, ao, held, hold_last;
        int            sent = 0, recv = 0, cyc = 0;
        beat_t         e;
        apply_reset();
        held = 1'b0;
        while (recv < 1000 && cyc < 20000) begin
            cyc++;
            v = (sent < 1000) && ($urandom_range(99, 0) < 70);
            d = rand_beat();
            l = ($urandom_range(7, 0) == 0);
            b = ($urandom_range(9, 0) == 0);
            r = ($urandom_range(1, 0) == 1);
            step(v, d, l, b, r, ai, ao);
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== hold_data || out_last !== hold_last) begin
                    errors++; $display("FAIL stall_hold cycle %0d got %b/%h/%b want 1/%h/%b", cyc, out_valid, out_data, out_last, hold_data, hold_last);
                end
            end
            if (ai) begin
                exp_q.push_back('{data: model_beat(d, b), last: l});
                sent++;
            end
            if (ao) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_extra_beat cycle %0d got %h want none", cyc, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_last !== e.last) begin
                        errors++; $display("FAIL rand_data beat %0d got %h/%b want %h/%b", recv, out_data, out_last, e.data, e.last);
                    end
                end
                recv++;
            end
            held      = out_valid & ~out_ready;
            hold_data = out_data;
            hold_last = out_last;
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, ai, ao);
        checks++; if (recv !== 1000) begin errors++; $display("FAIL rand_received got %0d want 1000", recv); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rand_leftover got %0d want 0", exp_q.size()); end
        checks++; if (beat_cnt !== 32'd1000) begin errors++; $display("FAIL rand_beat_cnt got %0d want 1000", beat_cnt); end
    endtask

    task automatic test_reset_midstream();
        logic ai, ao;
        int   sent = 0, k = 0;
        apply_reset();
        step(1'b1, rand_beat(), 1'b0, 1'b0, 1'b1, ai, ao);
        for (int j = 0; j < 4; j++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, ai, ao);
        while (sent < 3 && k < 10) begin
            k++;
            step(1'b1, rand_beat(), 1'b1, 1'b0, 1'b0, ai, ao);
            if (ai) sent++;
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, ai, ao);
        checks++; if (out_valid !== 1'b1 || beat_cnt !== 32'd1) begin
            errors++; $display("FAIL mid_prefill got %b/%0d want 1/1", out_valid, beat_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
        checks++; if (beat_cnt !== 32'd0) begin errors++; $display("FAIL mid_beat_cnt got %0d want 0", beat_cnt); end
        for (int j = 0; j < 10; j++) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b1, ai, ao);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_beat step %0d got %b want 0", j, out_valid); end
        end
    endtask

    task automatic test_beat_cnt_wrap();
        logic [31:0] want[3] = '{32'hFFFF_FFFF, 32'h0, 32'h1};
        logic        ai, ao, pending;
        int          sent = 0, idx = 0;
        apply_reset();
        @(negedge clk);
        force dut.beat_cnt = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        release dut.beat_cnt;
        @(negedge clk);
        checks++; if (beat_cnt !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_preload got %h want fffffffe", beat_cnt); end
        pending = 1'b0;
        for (int j = 0; j < 12; j++) begin
            step(sent < 3, rand_beat(), 1'b0, 1'b0, 1'b1, ai, ao);
            if (pending && idx < 3) begin
                checks++; if (beat_cnt !== want[idx]) begin errors++; $display("FAIL wrap_cnt%0d got %h want %h", idx, beat_cnt, want[idx]); end
                idx++;
            end
            if (ai) sent++;
            pending = ao;
        end
        checks++; if (idx !== 3) begin errors++; $display("FAIL wrap_beats got %0d want 3", idx); end
    endtask

    initial begin
        init_tables();
        test_reset();
        test_vectors();
        test_bypass();
        test_back_to_back();
        test_random_stall();
        test_reset_midstream();
        test_beat_cnt_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/silu_activation_unit.md
# silu_activation_unit

Streaming SiLU (x·sigmoid(x)) activation stage placed directly downstream of the normalization stage in the MobileViT datapath. It consumes LANES-wide vectors of signed Q8.8 values over a valid/ready handshake and applies a 16-segment piecewise-linear sigmoid followed by a rounded multiply. A per-beat bypass and a tile-end marker pass through unchanged. Results go out through a three-stage, back-pressurable pipeline toward the next matmul operand buffer.

## Interface
- LANES, 8: elements per beat
- DATA_W, 16: element width, signed Q8.8 (fixed; elaboration error otherwise)
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
- in_last  in  1  final beat of a tile
- in_bypass  in  1  beat passes through unmodified
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  LANES*DATA_W  activated data, same lane packing
- out_last  out  1  in_last, delayed with its beat
- beat_cnt  out  32  count of beats accepted at output, wraps at 2^32

## Operation
- Per lane, x signed 16-bit:
  - xc = clamp(x, -2048, 2047)
  - u = xc + 2048 (0..4095)
  - seg = u[11:8]
  - frac = u[7:0]
- s = SIG_ICPT[seg] + ((SIG_SLOPE[seg] * frac) >> 8), unsigned 9-bit, range 0..256.
- Override for x < -2048: s = 0.
- Override for x ≥ 2048: s = 256.
- y = (x * s + 128) >>> 8, computed on a 26-bit signed product. The magnitude of y never exceeds the magnitude of x, so no saturation logic is needed.
- SIG_ICPT[k] = round(256·σ(k−8)).
- SIG_SLOPE[k] = round(256·σ(k−7)) − SIG_ICPT[k], for k = 0..15.
- Bypass beat: y = x for all lanes.
- in_last and bypass travel with their beat through every stage.
- beat_cnt increments on each out_valid & out_ready.

## Timing
- Pipeline stages:
  - S1 registers xc, seg, frac, the x sign and the range flags.
  - S2 registers s.
  - S3 registers y.
- Latency: 3 cycles from input acceptance to out_valid with no stalls.
- Stage advance rule: stage k loads when its valid is 0 or stage k+1 loads. Stage S3 "loads" when out_ready or !out_valid.
- in_ready = S1 loads. Bubbles collapse, so with out_ready held high, throughput is 1 beat/cycle.
- in_ready is combinational from out_ready and the stage valids, never from in_valid.
- Handshake:
  - out_data and out_last are held stable while out_valid & !out_ready.
  - out_valid never drops without a handshake.
- Reset:
  - All stage valids, out_valid and beat_cnt go to 0. in_ready reads 1 the cycle after reset deasserts.
  - out_data and out_last go to 0.
  - Reset mid-stream discards all in-flight beats, with no partial output.
- Simultaneous accept at input and output with a full pipeline: both complete, and occupancy is unchanged.
- beat_cnt wrap: 0xFFFFFFFF → 0.

## Structure
- accelerator_activation_pkg holds:
  - SIG_ICPT and SIG_SLOPE as 16-entry localparam arrays
  - ACT_DATA_W = 16
  - ACT_CLAMP_LO = -2048 and ACT_CLAMP_HI = 2047
- Sub-module silu_lane holds the per-lane three-register datapath with a shared stage-enable input. It is instantiated LANES times.
- The top level holds the stage valids, the last/bypass pipeline, the handshake and beat_cnt.

## Test plan
- Lane inputs 0, 256, −256, −4096, 4096, 32767, −32768, 2047 with out_ready = 1. Required out_data after 3 cycles:
  - 0 → 0
  - 256 → 187
  - −256 → −69
  - −4096 → 0
  - 4096 → 4096
  - 32767 → 32767
  - −32768 → 0
  - 2047 → 2047 ± 1 LSB of the reference model
- Bypass beat with in_data = 0x8000 in every lane → out_data identical, and out_last matches in_last.
- 100 back-to-back beats with out_ready = 1 → out_valid is continuous from cycle 3 to cycle 102, and beat_cnt = 100.
- Random out_ready (50%) over 1000 random beats → output stays stable while stalled, order is preserved, no loss or duplication, and results match the bit-exact model.
- rst asserted for 1 cycle with 3 beats in flight → out_valid = 0 and beat_cnt = 0 next cycle, and none of the old beats appear afterward.
- beat_cnt preloaded to 0xFFFFFFFE via force, then 3 beats → 0xFFFFFFFF, 0, 1.
